// File: rtl/rgbled_stream.sv
// Serial RGB LED chain driver: shifts an N-bit frame out as T_BIT-cycle pulse-width slots
// followed by a low latch gap; "repeat" is a reserved word, so the chaining input is repeat_frame.
module rgbled_stream #(
    parameter int LEDS         = 4,
    parameter int BITS_PER_LED = 24,
    parameter int T_BIT        = 32,
    parameter int T0H          = 11,
    parameter int T1H          = 21,
    parameter int RES_CYCLES   = 1344
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic [LEDS*BITS_PER_LED-1:0] data,
    input  logic                         start,
    input  logic                         repeat_frame,
    output logic                         led,
    output logic                         busy,
    output logic                         done
);

    localparam int N  = LEDS * BITS_PER_LED;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
    localparam int RW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;

    localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
    localparam logic [TW-1:0] SLOT_LAST = TW'(T_BIT - 1);
    localparam logic [RW-1:0] GAP_LAST  = RW'(RES_CYCLES - 1);
    localparam logic [TW-1:0] HIGH0     = TW'(T0H);
    localparam logic [TW-1:0] HIGH1     = TW'(T1H);

    if (!(T0H >= 1 && T0H < T1H && T1H < T_BIT && RES_CYCLES >= 1 && N >= 1)) begin : g_bad_params
        $error("rgbled_stream: illegal timing parameters (need 1 <= T0H < T1H < T_BIT, RES_CYCLES >= 1, N >= 1)");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [N-1:0]  shadow, shadow_nx;
    logic [BW-1:0] bit_cnt, bit_nx;
    logic [TW-1:0] slot_cnt, slot_nx;
    logic [RW-1:0] gap_cnt, gap_nx;
    logic          led_nx, busy_nx, done_nx;
    logic [TW-1:0] high_len;

    always_comb begin
        state_nx  = state;
        shadow_nx = shadow;
        bit_nx    = bit_cnt;
        slot_nx   = slot_cnt;
        gap_nx    = gap_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = SEND;
                    shadow_nx = data;
                    bit_nx    = '0;
                    slot_nx   = '0;
                end
            end
            SEND: begin
                if (slot_cnt == SLOT_LAST) begin
                    slot_nx = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_nx = LATCH;
                        bit_nx   = '0;
                        gap_nx   = '0;
                    end else begin
                        bit_nx = bit_cnt + 1'b1;
                    end
                end else begin
                    slot_nx = slot_cnt + 1'b1;
                end
            end
            LATCH: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nx = '0;
                    // Chained frames reload here so slot 0 follows the gap with no idle cycle.
                    if (repeat_frame) begin
                        state_nx  = SEND;
                        shadow_nx = data;
                        bit_nx    = '0;
                        slot_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    gap_nx = gap_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are computed from next-state values so each flop shows the coming cycle directly.
    always_comb begin
        high_len = shadow_nx[bit_nx] ? HIGH1 : HIGH0;
        led_nx   = (state_nx == SEND) && (slot_nx < high_len);
        busy_nx  = (state_nx != IDLE);
        done_nx  = (state_nx == LATCH) && (gap_nx == GAP_LAST);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            shadow   <= '0;
            bit_cnt  <= '0;
            slot_cnt <= '0;
            gap_cnt  <= '0;
            led      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            shadow   <= shadow_nx;
            bit_cnt  <= bit_nx;
            slot_cnt <= slot_nx;
            gap_cnt  <= gap_nx;
            led      <= led_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_rgbled_stream.sv
// Scoreboard bench for rgbled_stream: per-cycle expected led/busy/done are queued when
// stimulus is driven and compared on each falling edge.
module tb_rgbled_stream;

    localparam int LEDS = 1, BPL = 4, TB = 8, T0 = 2, T1 = 5, RES = 10;

    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic [3:0] data = 4'b0000;
    logic       start = 1'b0;
    logic       rep = 1'b0;
    logic       led, busy, done;

    typedef struct packed {
        logic led;
        logic busy;
        logic done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    rgbled_stream #(
        .LEDS(LEDS), .BITS_PER_LED(BPL), .T_BIT(TB),
        .T0H(T0), .T1H(T1), .RES_CYCLES(RES)
    ) dut (
        .clk(clk), .nreset(nreset), .data(data), .start(start),
        .repeat_frame(rep), .led(led), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [3:0] d);
        exp_t e;
        for (int i = 0; i < BPL; i++) begin
            for (int t = 0; t < TB; t++) begin
                e.led  = (t < (d[i] ? T1 : T0));
                e.busy = 1'b1;
                e.done = 1'b0;
                q.push_back(e);
            end
        end
        for (int g = 0; g < RES; g++) begin
            e.led  = 1'b0;
            e.busy = 1'b1;
            e.done = (g == RES - 1);
            q.push_back(e);
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e = '0;
        for (int k = 0; k < n; k++) q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_underflow observed=empty expected=entry");
        end else begin
            e = q.pop_front();
            chk($sformatf("led@%0d", cyc), led, e.led);
            chk($sformatf("busy@%0d", cyc), busy, e.busy);
            chk($sformatf("done@%0d", cyc), done, e.done);
        end
    endtask

    task automatic drain();
        while (q.size() > 0) step();
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #1 nreset = 1'b0;
        #1;
        chk("reset_led", led, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        @(negedge clk);
        nreset = 1'b1;
        push_idle(2);
        drain();

        // Single frame 0101; data changed to 1111 mid-frame must not disturb it.
        data  = 4'b0101;
        start = 1'b1;
        push_frame(4'b0101);
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) step();
        data = 4'b1111;
        // Start while busy is ignored.
        start = 1'b1;
        for (int k = 0; k < 5; k++) step();
        start = 1'b0;
        drain();

        // Start raised in the done cycle: ignored there, accepted the cycle after busy falls.
        start = 1'b1;
        push_idle(1);
        push_frame(4'b1111);
        push_idle(3);
        step();
        step();
        start = 1'b0;
        drain();

        // Repeat: two chained frames, second picks up data changed during the first.
        data  = 4'b0011;
        rep   = 1'b1;
        start = 1'b1;
        push_frame(4'b0011);
        push_frame(4'b1001);
        push_idle(2);
        step();
        start = 1'b0;
        for (int k = 0; k < 19; k++) step();
        data = 4'b1001;
        for (int k = 0; k < 30; k++) step();
        rep = 1'b0;
        drain();

        // Mid-frame reset during bit 2 (high phase): outputs drop with no clock edge.
        data  = 4'b0101;
        start = 1'b1;
        push_frame(4'b0101);
        step();
        start = 1'b0;
        for (int k = 0; k < 16; k++) step();
        chk("bit2_led_high_before_reset", led, 1'b1);
        q.delete();
        #2 nreset = 1'b0;
        #1;
        chk("midreset_led", led, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_done", done, 1'b0);
        @(negedge clk);
        nreset = 1'b1;
        push_idle(4);
        drain();

        // Start held through reset release is accepted at the first edge.
        nreset = 1'b0;
        start  = 1'b1;
        data   = 4'b0110;
        @(negedge clk);
        nreset = 1'b1;
        push_frame(4'b0110);
        push_idle(2);
        step();
        start = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgbled_stream.md
RGBLED_STREAM -- requirements
Module: rgbled_stream

Interface
REQ-001 SHALL have parameter LEDS, default 4: number of LEDs in the chain.
REQ-002 SHALL have parameter BITS_PER_LED, default 24: bits per LED; N = LEDS*BITS_PER_LED.
REQ-003 SHALL have parameter T_BIT, default 32: clock cycles per bit slot.
REQ-004 SHALL have parameter T0H, default 11: high cycles for a 0 bit.
REQ-005 SHALL have parameter T1H, default 21: high cycles for a 1 bit.
REQ-006 SHALL have parameter RES_CYCLES, default 1344: low latch-gap cycles after each frame.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port nreset, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port data, input, N bits: frame source, sampled only at frame load.
REQ-010 SHALL have port start, input, 1 bit: request one frame.
REQ-011 SHALL have port repeat, input, 1 bit: chain the next frame without returning to idle.
REQ-012 SHALL have port led, output, 1 bit: serial LED drive, registered.
REQ-013 SHALL have port busy, output, 1 bit: a frame or latch gap is in progress.
REQ-014 SHALL have port done, output, 1 bit: single-cycle end-of-frame pulse.

Function
REQ-015 SHALL reject illegal parameters at elaboration: requires 1 <= T0H < T1H < T_BIT, RES_CYCLES >= 1 and N >= 1.
REQ-016 SHALL implement states IDLE, SEND and LATCH.
REQ-017 In IDLE with start=1 at an edge, SHALL copy data into an N-bit shadow register, clear the bit and timer counters, and enter SEND.
REQ-018 SHALL transmit shadow bits in index order 0 to N-1; each bit occupies exactly T_BIT cycles.
REQ-019 SHALL drive led=1 for the first H cycles of each slot and led=0 for the remaining T_BIT-H cycles, where H = T1H for a 1 bit and H = T0H for a 0 bit.
REQ-020 SHALL start the first slot's high phase in the cycle after start is accepted.
REQ-021 SHALL enter LATCH after the last cycle of slot N-1 and hold led=0 for exactly RES_CYCLES cycles.
REQ-022 SHALL assert done for one cycle in the final LATCH cycle.
REQ-023 SHALL sample repeat in the final LATCH cycle only:
- repeat=1: reload shadow from data and begin slot 0 in the next cycle, with no extra gap.
- repeat=0: enter IDLE.
REQ-024 SHALL hold busy=1 from the cycle after start is accepted through the final LATCH cycle inclusive; busy SHALL stay 1 across repeated frames.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL let start accept in the cycle immediately after busy falls.
REQ-027 SHALL keep data changes during SEND or LATCH from affecting the frame in flight.
REQ-028 SHALL make frame period exactly N*T_BIT + RES_CYCLES cycles.
REQ-029 SHALL size counters to $clog2 of their range, with a minimum of 1 bit, and wrap only by explicit reload, never by overflow.
REQ-030 SHALL keep led free of glitches: driven only from a flop.

Reset
REQ-031 While nreset=0, SHALL force, asynchronously and regardless of clk: led=0, busy=0, done=0, state IDLE, shadow=0, all counters=0.
REQ-032 SHALL abort any frame in flight when reset asserts mid-frame, with led low immediately.
REQ-033 After nreset deasserts, SHALL require a fresh start; start held high through deassertion SHALL be accepted at the first edge.

Verification
All scenarios use LEDS=1, BITS_PER_LED=4, T_BIT=8, T0H=2, T1H=5, RES_CYCLES=10.
REQ-034 Single frame: data=4'b0101, start pulse -> led high run lengths 5,2,5,2 within 8-cycle slots; then 10 low cycles; done once at cycle 42 after accept; busy high 42 cycles.
REQ-035 Data change: data changed to 4'b1111 during SEND -> the current frame is still 0101; the next frame uses the new value.
REQ-036 Repeat: repeat=1 held with two frames -> the second frame's first high cycle immediately follows the first done cycle; two done pulses; busy never drops between frames.
REQ-037 Start while busy: start asserted during SEND -> no effect. Back-to-back: start asserted the cycle after busy falls -> accepted.
REQ-038 Mid-frame reset: nreset low at bit 2 -> led, busy and done low without a clock edge; after release the line stays idle until start.
REQ-039 Illegal parameters: T0H=T1H -> elaboration fails.
